// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register offsets and FSM state encodings for irq_controller
package irq_ctrl_pkg;

  localparam logic [31:0] OFF_PEND = 32'h00;
  localparam logic [31:0] OFF_MASK = 32'h04;
  localparam logic [31:0] OFF_EDGE = 32'h08;
  localparam logic [31:0] OFF_CUR  = 32'h0C;
  localparam logic [31:0] OFF_CTRL = 32'h10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - rotating priority encoder: first set request at or above start, wrapping
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int IDW  = 2,
  parameter int RR   = 0
) (
  input  logic [NSRC-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic [IDW-1:0]  id,
  output logic            valid
);

  logic [IDW-1:0]    st;
  logic [2*NSRC-1:0] dbl;

  assign st  = (RR != 0) ? start : '0;
  assign dbl = {req, req} >> st;

  // Scan downward so the closest request to start is the last one assigned.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        id    = IDW'((int'(st) + k) % NSRC);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller: pending/mask/edge regs, arbitration, CPU handshake
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC      = 4,
  parameter int          IDW       = 2,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030,
  parameter int          RR        = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] src_irq,
  output logic            irq_out,
  output logic [IDW-1:0]  irq_vec,
  input  logic            irq_ack,
  input  logic            irq_done
);

  logic [NSRC-1:0] pend_q, mask_q, edge_q, prev_q;
  logic            ctrl_q;
  state_t          state_q, state_d;
  logic [IDW-1:0]  vec_q, vec_d, ptr_q, ptr_d;
  logic [NSRC-1:0] ev, eligible, w1c, ack_clr;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            hit_pend, hit_mask, hit_edge, hit_cur, hit_ctrl;
  logic            unused_wdata;

  assign hit_pend = (addr == BASE_ADDR + OFF_PEND);
  assign hit_mask = (addr == BASE_ADDR + OFF_MASK);
  assign hit_edge = (addr == BASE_ADDR + OFF_EDGE);
  assign hit_cur  = (addr == BASE_ADDR + OFF_CUR);
  assign hit_ctrl = (addr == BASE_ADDR + OFF_CTRL);
  assign unused_wdata = ^wdata[31:NSRC];

  // Edge-mode bits fire only on a 0->1 transition; level-mode bits fire every high cycle.
  assign ev       = src_irq & ~(edge_q & prev_q);
  assign eligible = ctrl_q ? (pend_q & mask_q) : '0;
  assign w1c      = (wr && hit_pend) ? wdata[NSRC-1:0] : '0;

  irq_prio_enc #(.NSRC(NSRC), .IDW(IDW), .RR(RR)) u_prio (
    .req  (eligible),
    .start(ptr_q),
    .id   (win_id),
    .valid(win_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ptr_d   = ptr_q;
    ack_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          vec_d   = win_id;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          ack_clr = NSRC'(1) << vec_q;
          state_d = S_SVC;
        end else if ((eligible & (NSRC'(1) << vec_q)) == '0) begin
          state_d = S_IDLE;
        end
      end
      S_SVC: begin
        if (irq_done) begin
          state_d = S_IDLE;
          if (RR != 0) ptr_d = (vec_q == IDW'(NSRC - 1)) ? '0 : vec_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      ctrl_q  <= 1'b0;
      state_q <= S_IDLE;
      vec_q   <= '0;
      ptr_q   <= '0;
    end else begin
      // A new event beats any clear landing in the same cycle.
      pend_q  <= (pend_q & ~(w1c | ack_clr)) | ev;
      prev_q  <= src_irq;
      state_q <= state_d;
      vec_q   <= vec_d;
      ptr_q   <= ptr_d;
      if (wr && hit_mask) mask_q <= wdata[NSRC-1:0];
      if (wr && hit_edge) edge_q <= wdata[NSRC-1:0];
      if (wr && hit_ctrl) ctrl_q <= wdata[0];
    end
  end

  assign irq_out = (state_q == S_REQ);
  assign irq_vec = vec_q;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (hit_pend) rdata[NSRC-1:0] = pend_q;
      else if (hit_mask) rdata[NSRC-1:0] = mask_q;
      else if (hit_edge) rdata[NSRC-1:0] = edge_q;
      else if (hit_ctrl) rdata[0] = ctrl_q;
      else if (hit_cur) begin
        rdata[8]       = (state_q != S_IDLE);
        rdata[5:4]     = state_q;
        rdata[IDW-1:0] = vec_q;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - fixed (dut0) and rotating (dut1) priority instances against a behavioural model
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0030;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, irq_ack, irq_done;
  logic [31:0] addr, wdata;
  logic [3:0]  src_irq;
  logic [31:0] rdata0, rdata1;
  logic        irq_out0, irq_out1;
  logic [1:0]  vec0, vec1;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  irq_controller #(.NSRC(4), .IDW(2), .BASE_ADDR(BASE), .RR(0)) dut0 (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .src_irq(src_irq), .irq_out(irq_out0), .irq_vec(vec0),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  irq_controller #(.NSRC(4), .IDW(2), .BASE_ADDR(BASE), .RR(1)) dut1 (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .src_irq(src_irq), .irq_out(irq_out1), .irq_vec(vec1),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  // Model state: registers shared by both instances, per-instance pending/state/vector/pointer.
  logic [3:0] m_mask, m_edge, m_prev;
  logic       m_ctrl;
  logic [3:0] m_pend [2];
  int         m_state [2];
  int         m_vec [2];
  int         m_ptr [2];
  logic [3:0] ev_t, elig_t, clr_t;

  function automatic int pick(input logic [3:0] e, input int start);
    for (int k = 0; k < 4; k++) begin
      if (((e >> ((start + k) % 4)) & 4'b1) != 4'b0) return (start + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mask <= 4'h0; m_edge <= 4'h0; m_prev <= 4'h0; m_ctrl <= 1'b0;
      for (int u = 0; u < 2; u++) begin
        m_pend[u] <= 4'h0; m_state[u] <= 0; m_vec[u] <= 0; m_ptr[u] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) ev_t[i] = src_irq[i] && (m_edge[i] ? !m_prev[i] : 1'b1);
      for (int u = 0; u < 2; u++) begin
        elig_t = m_ctrl ? (m_pend[u] & m_mask) : 4'h0;
        clr_t  = (wr && addr == BASE + OFF_PEND) ? wdata[3:0] : 4'h0;
        case (m_state[u])
          0: if (elig_t != 4'h0) begin
               m_vec[u] <= pick(elig_t, (u == 1) ? m_ptr[u] : 0);
               m_state[u] <= 1;
             end
          1: if (irq_ack) begin
               clr_t = clr_t | (4'b1 << m_vec[u]);
               m_state[u] <= 2;
             end else if (((elig_t >> m_vec[u]) & 4'b1) == 4'b0) m_state[u] <= 0;
          default: if (irq_done) begin
               m_state[u] <= 0;
               if (u == 1) m_ptr[u] <= (m_vec[u] + 1) % 4;
             end
        endcase
        m_pend[u] <= (m_pend[u] & ~clr_t) | ev_t;
      end
      if (wr && addr == BASE + OFF_MASK) m_mask <= wdata[3:0];
      if (wr && addr == BASE + OFF_EDGE) m_edge <= wdata[3:0];
      if (wr && addr == BASE + OFF_CTRL) m_ctrl <= wdata[0];
      m_prev <= src_irq;
    end
  end

  function automatic logic [31:0] m_rdata(input int u);
    if (!rd) return 32'h0;
    if (addr == BASE + OFF_PEND) return {28'h0, m_pend[u]};
    if (addr == BASE + OFF_MASK) return {28'h0, m_mask};
    if (addr == BASE + OFF_EDGE) return {28'h0, m_edge};
    if (addr == BASE + OFF_CTRL) return {31'h0, m_ctrl};
    if (addr == BASE + OFF_CUR)
      return ((m_state[u] != 0) ? 32'h100 : 32'h0) | (32'(m_state[u]) << 4) | 32'(m_vec[u]);
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      check("dut0 irq_out", {31'h0, irq_out0}, {31'h0, m_state[0] == 1});
      check("dut0 irq_vec", {30'h0, vec0}, 32'(m_vec[0]));
      check("dut0 rdata", rdata0, m_rdata(0));
      check("dut1 irq_out", {31'h0, irq_out1}, {31'h0, m_state[1] == 1});
      check("dut1 irq_vec", {30'h0, vec1}, 32'(m_vec[1]));
      check("dut1 rdata", rdata1, m_rdata(1));
    end
  end

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
    wr = 1'b1; addr = BASE + off; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic chk_rd(input logic [31:0] off, input logic [31:0] exp, input string name);
    rd = 1'b1; addr = BASE + off;
    #1;
    check(name, rdata0, exp);
    rd = 1'b0; addr = 32'h0;
  endtask

  task automatic pulse(input bit a, input bit d);
    irq_ack = a; irq_done = d;
    @(negedge clk);
    irq_ack = 1'b0; irq_done = 1'b0;
  endtask

  int rr_exp [3] = '{0, 1, 0};

  initial begin
    rd = 0; wr = 0; addr = 0; wdata = 0; src_irq = 0; irq_ack = 0; irq_done = 0; reset = 0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    check("rst irq_out", {31'h0, irq_out0}, 32'h0);
    check("rst irq_vec", {30'h0, vec0}, 32'h0);
    chk_rd(OFF_PEND, 32'h0, "rst pend");
    chk_rd(OFF_CUR, 32'h0, "rst cur");
    reset = 1'b1;
    @(negedge clk);

    // Single edge source: latency and handshake.
    wr_reg(OFF_MASK, 32'hF); wr_reg(OFF_EDGE, 32'hF); wr_reg(OFF_CTRL, 32'h1);
    src_irq = 4'b0100; @(negedge clk); src_irq = 4'b0;
    chk_rd(OFF_PEND, 32'h4, "pend latch");
    check("irq_out at n+1", {31'h0, irq_out0}, 32'h0);
    @(negedge clk);
    check("irq_out at n+2", {31'h0, irq_out0}, 32'h1);
    check("vec at n+2", {30'h0, vec0}, 32'h2);
    pulse(1, 0);
    chk_rd(OFF_PEND, 32'h0, "pend after ack");
    check("irq_out in svc", {31'h0, irq_out0}, 32'h0);
    chk_rd(OFF_CUR, 32'h122, "cur in svc");
    pulse(0, 1);
    chk_rd(OFF_CUR, 32'h002, "cur after done");

    // Simultaneous sources, fixed priority.
    src_irq = 4'b1010; @(negedge clk); src_irq = 4'b0;
    @(negedge clk);
    check("simul first vec", {30'h0, vec0}, 32'h1);
    pulse(1, 0); pulse(0, 1);
    @(negedge clk);
    check("simul second vec", {30'h0, vec0}, 32'h3);
    check("simul second irq", {31'h0, irq_out0}, 32'h1);
    pulse(1, 0); pulse(0, 1);

    // Rotation with level sources held high.
    wr_reg(OFF_EDGE, 32'h0);
    src_irq = 4'b0011; @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rr vec %0d", i), {30'h0, vec1}, 32'(rr_exp[i]));
      check($sformatf("fixed vec %0d", i), {30'h0, vec0}, 32'h0);
      pulse(1, 0); pulse(0, 1);
      @(negedge clk);
    end
    src_irq = 4'b0; @(negedge clk);
    wr_reg(OFF_PEND, 32'hF);
    @(negedge clk);
    check("w1c withdraw dut0", {31'h0, irq_out0}, 32'h0);
    check("w1c withdraw dut1", {31'h0, irq_out1}, 32'h0);
    wr_reg(OFF_EDGE, 32'hF);

    // Withdraw by masking.
    src_irq = 4'b0100; @(negedge clk); src_irq = 4'b0;
    @(negedge clk);
    check("pre-mask vec", {30'h0, vec0}, 32'h2);
    wr_reg(OFF_MASK, 32'hB);
    @(negedge clk);
    check("mask withdraw irq", {31'h0, irq_out0}, 32'h0);
    chk_rd(OFF_CUR, 32'h002, "mask withdraw cur");
    chk_rd(OFF_PEND, 32'h4, "mask keeps pend");
    wr_reg(OFF_MASK, 32'hF); wr_reg(OFF_PEND, 32'h4);
    @(negedge clk);
    check("clear withdraw irq", {31'h0, irq_out0}, 32'h0);

    // W1C racing a new edge: set wins.
    wr_reg(OFF_CTRL, 32'h0);
    src_irq = 4'b0001; wr_reg(OFF_PEND, 32'h1); src_irq = 4'b0;
    chk_rd(OFF_PEND, 32'h1, "w1c race set wins");
    wr_reg(OFF_PEND, 32'h1);
    chk_rd(OFF_PEND, 32'h0, "w1c alone");
    wr_reg(OFF_CTRL, 32'h1);

    // Stray handshakes in IDLE.
    pulse(1, 0);
    chk_rd(OFF_CUR, 32'h002, "stray ack cur");
    pulse(0, 1);
    check("stray done irq", {31'h0, irq_out0}, 32'h0);

    // ack and done together in REQ, then reset during SVC.
    src_irq = 4'b0010; @(negedge clk); src_irq = 4'b0;
    @(negedge clk);
    check("pre-svc vec", {30'h0, vec0}, 32'h1);
    pulse(1, 1);
    chk_rd(OFF_CUR, 32'h121, "ack+done goes svc");
    reset = 1'b0;
    rd = 1'b1; addr = BASE + OFF_PEND; #1;
    check("async rst pend", rdata0, 32'h0);
    check("async rst irq_out", {31'h0, irq_out0}, 32'h0);
    addr = BASE + OFF_MASK; #1;
    check("async rst mask", rdata0, 32'h0);
    rd = 1'b0; addr = 32'h0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_rd(OFF_CUR, 32'h0, "post-reset cur");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the CPU peripheral bus, at BASE_ADDR..BASE_ADDR+0x10 (default 0x40000030, directly above the existing peripheral registers).
- Collects NSRC interrupt sources (timer overflow, UART rx-ready, UART tx-done, switch change), latches them as pending, masks them, arbitrates among them, and drives the single CPU interrupt line.
- Handshakes with the CPU through ack (handler entry) and done (return from exception). Nesting is not supported.

Parameters:
- NSRC, 4: number of interrupt sources, 2..8.
- IDW, 2: vector width; must equal clog2(NSRC).
- BASE_ADDR, 32'h40000030: register block base address.
- RR, 0: 0 = fixed priority (lowest index wins); 1 = rotating priority.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd  in  1  bus read strobe
- wr  in  1  bus write strobe
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational
- src_irq  in  NSRC  source requests, synchronous to clk
- irq_out  out  1  interrupt request to CPU
- irq_vec  out  IDW  id of the source being requested or serviced
- irq_ack  in  1  one-cycle pulse: CPU entered handler
- irq_done  in  1  one-cycle pulse: CPU executed eret

Behaviour:
- Reset: all registers zero. State IDLE. irq_out=0, irq_vec=0, prev-sample register=0, rotate pointer=0.
- Register map (offset, access):
  - 0x00 PEND, R / write-1-to-clear.
  - 0x04 MASK, RW, 1 = enabled.
  - 0x08 EDGE, RW, 1 = rising-edge sensitive, 0 = level sensitive.
  - 0x0C CUR, R: {active bit at [8], state at [5:4], id at [IDW-1:0]}.
  - 0x10 CTRL, RW: bit0 global enable.
  - Unused upper bits read 0.
- rdata: selected register when rd and addr match, else 0. Unmapped addresses read 0; writes to them are ignored.
- Event detection:
  - Edge mode: event when src_irq=1 and prev=0.
  - Level mode: event every cycle src_irq=1.
- PEND update:
  - pend[i] is set on an event regardless of MASK.
  - pend[i] is cleared by a W1C write, or by irq_ack for the acked id.
  - If set and clear occur in the same cycle, set wins. A level source held high therefore stays pending.
- Latency: event in cycle n -> PEND bit visible in n+1 -> irq_out=1 in n+2 (IDLE, enabled).
- eligible = PEND & MASK, gated by CTRL[0].
- FSM (2-bit):
  - IDLE: if any bit of eligible is set, latch winner id into irq_vec and go to REQ.
  - REQ: irq_out=1.
    - On irq_ack: clear pend[id], go to SVC.
    - Else if eligible[id] drops (masked, cleared, or enable off): withdraw, irq_out=0 next cycle, go to IDLE.
    - A higher-priority source arriving during REQ does not preempt the latched id.
  - SVC: irq_out=0, irq_vec holds id. New events accumulate in PEND without being requested. On irq_done: go to IDLE; with RR=1, rotate pointer = id+1 mod NSRC.
  - Stray inputs: irq_ack outside REQ and irq_done outside SVC are ignored. If ack and done arrive in the same cycle, only the one valid for the current state is honoured.
  - Clearing CTRL[0] during SVC does not abort; the FSM waits for irq_done.
- Arbitration:
  - RR=0: lowest set index wins.
  - RR=1: first set index scanning upward from the rotate pointer, wrapping at NSRC-1 to 0.
- Reset mid-operation: immediate return to IDLE, irq_out=0 asynchronously; all pending bits are lost.

Decomposition:
- Package irq_ctrl_pkg:
  - Register offsets OFF_PEND/OFF_MASK/OFF_EDGE/OFF_CUR/OFF_CTRL.
  - State encodings S_IDLE=2'd0, S_REQ=2'd1, S_SVC=2'd2.
- Sub-module irq_prio_enc: combinational rotating priority encoder. Inputs: req[NSRC], start[IDW]. Outputs: id[IDW], valid. RR=0 ties start to 0.

Test Plan:
- Setup: MASK=0xF, EDGE=0xF, CTRL=1. Pulse src_irq=4'b0100 for one cycle -> PEND=0x4 next cycle; irq_out=1, irq_vec=2 two cycles after the pulse. Pulse irq_ack -> PEND=0, irq_out=0. Pulse irq_done -> CUR state=IDLE.
- Simultaneous sources, RR=0: src_irq=4'b1010 -> vec=1 first. After ack+done -> vec=3.
- Rotation, RR=1: keep 4'b0011 pending via level mode (EDGE=0). Ack+done three times -> vec sequence 0, 1, 0.
- Withdraw: in REQ with vec=2, write MASK=0xB -> irq_out=0 next cycle, state=IDLE, PEND bit 2 still 1.
- W1C race: write PEND=0x1 in the same cycle as a new edge on src 0 -> PEND[0]=1 afterwards. A later W1C alone -> 0.
- Stray and reset: irq_ack while IDLE -> no change. Assert reset during SVC -> irq_out=0, PEND=0, MASK=0 immediately; after release, a read of CUR returns 0.
